// File: rtl/alu_pkg.sv
// Shared ALU definitions: select encodings, multicycle classification and
// the issue-stage FSM state type. Used by alu, decode and alu_issue.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_LT  = 4'b1001;
    localparam logic [3:0] ALU_EQ  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_HOLD = 2'b10
    } issue_state_t;

    // Multiply and divide are the multicycle paths through the alu.
    function automatic logic is_muldiv(input logic [3:0] sel);
        return (sel == ALU_MUL) || (sel == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Small synchronous FIFO with registered head. Besides the head entry it
// exposes one field (PEEK_LSB/PEEK_W) of the entry behind the head so the
// owner can look one operation ahead when the head is popped.
module alu_issue_fifo #(
    parameter int W        = 8,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 2,
    parameter int PEEK_LSB = 0,
    parameter int PEEK_W   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      head,
    output logic [PEEK_W-1:0] next_peek,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [W-1:0]     second_s;

    // Pointers advance modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Storage, pointers and occupancy; push/pop are pre-qualified by the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign second_s  = mem_r[ptr_inc(rd_ptr_r)];
    assign next_peek = second_s[PEEK_LSB +: PEEK_W];
    assign count     = count_r;

endmodule

// File: rtl/alu_issue.sv
// Operand issue stage in front of the combinational alu. Buffers decoded
// ops, holds the head on the alu inputs for its required cycles (multiply
// and divide take MULDIV_CYCLES) and registers the result toward writeback.
module alu_issue
    import alu_pkg::*;
#(
    parameter int N             = 32,
    parameter int DEPTH         = 2,
    parameter int TAG_W         = 5,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [3:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_sel,
    input  logic [N-1:0]     alu_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int ENT_W = 2 * N + 4 + TAG_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MC_W  = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [MC_W-1:0]  MD_LAST = MC_W'(MULDIV_CYCLES - 1);

    // Last value of the evaluation counter for a given select.
    function automatic logic [MC_W-1:0] need_m1(input logic [3:0] sel);
        return is_muldiv(sel) ? MD_LAST : '0;
    endfunction

    issue_state_t     state_r;
    issue_state_t     state_next_s;
    logic [MC_W-1:0]  cnt_r;
    logic             out_valid_r;
    logic [N-1:0]     out_res_r;
    logic [TAG_W-1:0] out_tag_r;

    logic [ENT_W-1:0] head_s;
    logic [3:0]       peek_sel_s;
    logic [CNT_W-1:0] count_s;
    logic             empty_s;
    logic             push_s;
    logic [N-1:0]     head_a_s;
    logic [N-1:0]     head_b_s;
    logic [3:0]       head_sel_s;
    logic [TAG_W-1:0] head_tag_s;
    logic             cnt_done_s;
    logic             slot_free_s;
    logic             capture_s;
    logic             inc_s;
    logic [CNT_W-1:0] count_next_s;
    logic [3:0]       sel_next_s;
    logic [MC_W-1:0]  cnt_next_s;
    logic             ov_next_s;
    issue_state_t     target_s;

    alu_issue_fifo #(
        .W        (ENT_W),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W),
        .PEEK_LSB (TAG_W),
        .PEEK_W   (4)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (capture_s),
        .wdata     ({in_a, in_b, in_sel, in_tag}),
        .head      (head_s),
        .next_peek (peek_sel_s),
        .count     (count_s)
    );

    assign empty_s    = (count_s == '0);
    assign in_ready   = (count_s < DEPTH_C);
    assign push_s     = in_valid && in_ready;
    assign head_a_s   = head_s[ENT_W-1 -: N];
    assign head_b_s   = head_s[TAG_W+4 +: N];
    assign head_sel_s = head_s[TAG_W +: 4];
    assign head_tag_s = head_s[TAG_W-1:0];
    assign cnt_done_s  = (cnt_r == need_m1(head_sel_s));
    assign slot_free_s = !out_valid_r || out_ready;

    // An empty FIFO presents zeros to the alu; otherwise the stored head.
    assign alu_a   = empty_s ? '0 : head_a_s;
    assign alu_b   = empty_s ? '0 : head_b_s;
    assign alu_sel = empty_s ? 4'b0000 : head_sel_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Look one cycle ahead: occupancy, head select, counter and slot after this edge.
    always_comb begin
        count_next_s = count_s;
        sel_next_s   = head_sel_s;
        cnt_next_s   = cnt_r;
        ov_next_s    = out_valid_r;
        case ({push_s, capture_s})
            2'b10:   count_next_s = count_s + CNT_W'(1);
            2'b01:   count_next_s = count_s - CNT_W'(1);
            default: count_next_s = count_s;
        endcase
        if (capture_s) begin
            sel_next_s = (count_s > CNT_W'(1)) ? peek_sel_s : in_sel;
            cnt_next_s = '0;
            ov_next_s  = 1'b1;
        end else if (empty_s) begin
            sel_next_s = in_sel;
            cnt_next_s = cnt_r;
            ov_next_s  = out_valid_r && !out_ready;
        end else begin
            sel_next_s = head_sel_s;
            cnt_next_s = inc_s ? (cnt_r + MC_W'(1)) : cnt_r;
            ov_next_s  = out_valid_r && !out_ready;
        end
        if (count_next_s == '0) begin
            target_s = ST_IDLE;
        end else if ((cnt_next_s == need_m1(sel_next_s)) && ov_next_s) begin
            target_s = ST_HOLD;
        end else begin
            target_s = ST_EVAL;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (push_s) begin
                    state_next_s = target_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EVAL: state_next_s = target_s;
            ST_HOLD: state_next_s = target_s;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: advance the counter while evaluating, capture when done and slot free.
    always_comb begin
        capture_s = 1'b0;
        inc_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                capture_s = 1'b0;
                inc_s     = 1'b0;
            end
            ST_EVAL: begin
                if (cnt_done_s) begin
                    capture_s = slot_free_s;
                end else begin
                    inc_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (slot_free_s) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            default: begin
                capture_s = 1'b0;
                inc_s     = 1'b0;
            end
        endcase
    end

    // Evaluation counter: restarts for each new head, saturates at need-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (capture_s) begin
            cnt_r <= '0;
        end else if (inc_s) begin
            cnt_r <= cnt_r + MC_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result register toward writeback; held while writeback stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_res_r   <= '0;
            out_tag_r   <= '0;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            out_res_r   <= alu_res;
            out_tag_r   <= head_tag_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_tag   = out_tag_r;
    assign busy      = !empty_s || out_valid_r;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural alu closing the loop.
module tb_alu_issue;

    localparam int N     = 32;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [3:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_sel;
    logic [N-1:0]     alu_res;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_res;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue #(.N(N), .DEPTH(2), .TAG_W(TAG_W), .MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu; divide by zero yields all ones, undefined selects yield 0.
    always_comb begin
        case (alu_sel)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0001: alu_res = alu_a - alu_b;
            4'b0010: alu_res = alu_a * alu_b;
            4'b0011: alu_res = (alu_b == '0) ? '1 : alu_a / alu_b;
            4'b0110: alu_res = alu_a & alu_b;
            4'b0111: alu_res = alu_a | alu_b;
            4'b1000: alu_res = alu_a ^ alu_b;
            4'b1001: alu_res = {31'd0, alu_a < alu_b};
            4'b1010: alu_res = {31'd0, alu_a == alu_b};
            default: alu_res = '0;
        endcase
    end

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [4:0] tag);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        #2;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_alu_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single add 3 + 5, tag 7.
        drive(1'b1, 32'd3, 32'd5, 4'b0000, 5'd7);
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        check_val("add_alu_a", alu_a, 3);
        check_val("add_alu_b", alu_b, 5);
        check_val("add_not_yet", out_valid, 0);
        tick();
        check_val("add_valid", out_valid, 1);
        check_val("add_res", out_res, 8);
        check_val("add_tag", out_tag, 7);
        tick();
        check_val("add_busy_after", busy, 0);
        check_val("add_drained", out_valid, 0);

        // Back-to-back: sub, xor, eq.
        drive(1'b1, 32'd10, 32'd4, 4'b0001, 5'd1);
        tick();
        drive(1'b1, 32'h0F0, 32'h0FF, 4'b1000, 5'd2);
        tick();
        check_val("b2b_res0", out_res, 6);
        check_val("b2b_tag0", out_tag, 1);
        drive(1'b1, 32'd5, 32'd5, 4'b1010, 5'd3);
        tick();
        check_val("b2b_res1", out_res, 32'h0F);
        check_val("b2b_tag1", out_tag, 2);
        check_val("b2b_valid1", out_valid, 1);
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        tick();
        check_val("b2b_res2", out_res, 1);
        check_val("b2b_tag2", out_tag, 3);
        tick();
        check_val("b2b_drained", out_valid, 0);

        // Multicycle mul 6 * 7 held for four cycles.
        drive(1'b1, 32'd6, 32'd7, 4'b0010, 5'd4);
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("mul_a_c%0d", i), alu_a, 6);
            check_val($sformatf("mul_b_c%0d", i), alu_b, 7);
            check_val($sformatf("mul_sel_c%0d", i), alu_sel, 4'b0010);
            check_val($sformatf("mul_wait_c%0d", i), out_valid, 0);
            tick();
        end
        check_val("mul_valid", out_valid, 1);
        check_val("mul_res", out_res, 42);
        check_val("mul_tag", out_tag, 4);
        tick();

        // Backpressure: three ops with writeback stalled.
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 4'b0000, 5'd10);
        tick();
        drive(1'b1, 32'd9, 32'd3, 4'b0001, 5'd11);
        tick();
        check_val("bp_first_valid", out_valid, 1);
        drive(1'b1, 32'h0C, 32'h03, 4'b0111, 5'd12);
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        check_val("bp_full", in_ready, 0);
        check_val("bp_hold_res", out_res, 2);
        check_val("bp_hold_tag", out_tag, 10);
        tick();
        check_val("bp_still_res", out_res, 2);
        check_val("bp_still_tag", out_tag, 10);
        check_val("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check_val("bp_res1", out_res, 6);
        check_val("bp_tag1", out_tag, 11);
        check_val("bp_ready_again", in_ready, 1);
        tick();
        check_val("bp_res2", out_res, 32'h0F);
        check_val("bp_tag2", out_tag, 12);
        check_val("bp_valid2", out_valid, 1);
        tick();
        check_val("bp_drained", out_valid, 0);
        check_val("bp_idle", busy, 0);

        // Reset during cycle 2 of a divide.
        drive(1'b1, 32'd100, 32'd7, 4'b0011, 5'd5);
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        tick();
        check_val("div_in_flight", alu_sel, 4'b0011);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_out_valid", out_valid, 0);
        check_val("rst_mid_alu_a", alu_a, 0);
        check_val("rst_mid_alu_sel", alu_sel, 0);
        check_val("rst_mid_in_ready", in_ready, 1);
        check_val("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_val("rst_no_result", seen, 0);

        // Undefined select 1111 passes the alu's zero after one cycle.
        drive(1'b1, 32'd3, 32'd4, 4'b1111, 5'd20);
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        tick();
        check_val("undef_valid", out_valid, 1);
        check_val("undef_res", out_res, 0);
        check_val("undef_tag", out_tag, 20);
        tick();

        // Divide by zero is multicycle and passes the alu value through.
        drive(1'b1, 32'd9, 32'd0, 4'b0011, 5'd21);
        tick();
        drive(1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("div0_wait_c%0d", i), out_valid, 0);
            tick();
        end
        check_val("div0_valid", out_valid, 1);
        check_val("div0_res", out_res, 32'hFFFF_FFFF);
        check_val("div0_tag", out_tag, 21);
        tick();
        check_val("div0_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
